// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Ports: clk/rst (sync, active-high), start/funct3/aluIn1/aluIn2 in; busy/done/result out.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] aluIn1,
  input  logic [WIDTH-1:0] aluIn2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [2:0]       opReg;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [CW-1:0]    cnt;
  // Multiply: upper half accumulates, lower half holds the
  // remaining multiplier bits and shifts right each step.
  logic [2*WIDTH-1:0] prod;
  // Divide: quoR starts as the dividend and fills with quotient bits.
  logic [WIDTH-1:0] remR;
  logic [WIDTH-1:0] quoR;

  // Acceptance-side decode
  logic             saIn;
  logic             sbIn;
  logic [WIDTH-1:0] absAIn;
  logic [WIDTH-1:0] absBIn;
  logic             isDiv;
  logic             divZero;
  logic             divOvf;
  logic [WIDTH-1:0] specialRes;

  always_comb begin
    saIn = 1'b0;
    sbIn = 1'b0;
    unique case (funct3)
      3'b001: begin
        saIn = aluIn1[WIDTH-1];
        sbIn = aluIn2[WIDTH-1];
      end
      3'b010: saIn = aluIn1[WIDTH-1];
      3'b100, 3'b110: begin
        saIn = aluIn1[WIDTH-1];
        sbIn = aluIn2[WIDTH-1];
      end
      default: begin
        saIn = 1'b0;
        sbIn = 1'b0;
      end
    endcase
  end

  assign absAIn  = saIn ? (~aluIn1 + 1'b1) : aluIn1;
  assign absBIn  = sbIn ? (~aluIn2 + 1'b1) : aluIn2;
  assign isDiv   = funct3[2];
  assign divZero = isDiv && (aluIn2 == '0);
  // Signed overflow only exists for DIV/REM (funct3[0]==0).
  assign divOvf  = isDiv && !funct3[0] &&
                   (aluIn1 == MINV) && (aluIn2 == '1);

  always_comb begin
    specialRes = '0;
    if (divZero)
      specialRes = funct3[1] ? aluIn1 : '1;
    else
      specialRes = funct3[1] ? '0 : MINV;
  end

  // One shift-add step
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prodNext;

  assign mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (prod[0] ? {1'b0, absA} : '0);
  assign prodNext = {mulSum, prod[WIDTH-1:1]};

  // One restoring-divide step
  logic [WIDTH:0]   divTrial;
  logic [WIDTH:0]   divDiff;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;

  assign divTrial = {remR, quoR[WIDTH-1]};
  assign divDiff  = divTrial - {1'b0, absB};

  always_comb begin
    if (!divDiff[WIDTH]) begin
      remNext = divDiff[WIDTH-1:0];
      quoNext = {quoR[WIDTH-2:0], 1'b1};
    end else begin
      remNext = divTrial[WIDTH-1:0];
      quoNext = {quoR[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up on the final step's values
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   finalRes;

  assign prodFix = (sa ^ sb) ? (~prodNext + 1'b1) : prodNext;
  assign quoFix  = (sa ^ sb) ? (~quoNext + 1'b1) : quoNext;
  assign remFix  = sa ? (~remNext + 1'b1) : remNext;

  always_comb begin
    finalRes = '0;
    unique case (opReg)
      3'b000:                 finalRes = prodFix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: finalRes = prodFix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         finalRes = quoFix;
      3'b110, 3'b111:         finalRes = remFix;
      default:                finalRes = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      opReg  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      absA   <= '0;
      absB   <= '0;
      cnt    <= '0;
      prod   <= '0;
      remR   <= '0;
      quoR   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opReg <= funct3;
            sa    <= saIn;
            sb    <= sbIn;
            absA  <= absAIn;
            absB  <= absBIn;
            cnt   <= '0;
            prod  <= {{WIDTH{1'b0}}, absBIn};
            remR  <= '0;
            quoR  <= absAIn;
            busy  <= 1'b1;
            if (divZero || divOvf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= specialRes;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (opReg[2]) begin
            remR <= remNext;
            quoR <= quoNext;
          end else begin
            prod <= prodNext;
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= finalRes;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit.
// Random and directed RV32M ops against an arithmetic reference.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] aluIn1 = '0;
  logic [31:0] aluIn2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .funct3(funct3),
    .aluIn1(aluIn1),
    .aluIn2(aluIn2),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          doneEdge;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  logic rstSeen = 1'b1;
  logic [31:0] prevResult = '0;

  always @(posedge clk) begin
    edgeCount <= edgeCount + 1;
    rstSeen   <= rst;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] refRes(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sA;
    logic [63:0] sB;
    logic [63:0] uA;
    logic [63:0] uB;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sA  = {{32{a[31]}}, a};
    sB  = {{32{b[31]}}, b};
    uA  = {32'b0, a};
    uB  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sA * sB; r = p[31:0]; end
      3'd1: begin p = sA * sB; r = p[63:32]; end
      3'd2: begin p = sA * uB; r = p[63:32]; end
      3'd3: begin p = uA * uB; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  task automatic pushExp(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int acceptEdge);
    exp_t e;
    e.op       = op;
    e.a        = a;
    e.b        = b;
    e.res      = refRes(op, a, b);
    e.doneEdge = acceptEdge + latency(op, a, b) - 1;
    q.push_back(e);
  endtask

  // Drives one request in an idle cycle and scrambles inputs afterwards
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL issueTimeout: busy=%b expected 0", busy);
    end
    start  = 1'b1;
    funct3 = op;
    aluIn1 = a;
    aluIn2 = b;
    pushExp(op, a, b, edgeCount + 1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    aluIn1 = $urandom;
    aluIn2 = $urandom;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done) begin
      check("doneWithBusy", {31'b0, busy}, 32'd1);
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spuriousDone: got done=1 expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("result op%0d a=%h b=%h", e.op, e.a, e.b),
              result, e.res);
        check($sformatf("latency op%0d", e.op),
              32'(edgeCount), 32'(e.doneEdge));
      end
    end else if (!rstSeen) begin
      check("resultHold", result, prevResult);
    end
    prevResult <= result;
  end

  initial begin
    int cnt;
    int guard;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resetBusy", {31'b0, busy}, 32'd0);
    check("resetDone", {31'b0, done}, 32'd0);
    check("resetResult", result, 32'd0);
    rst = 1'b0;

    // MUL with busy-width measurement
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    cnt = 0;
    guard = 0;
    while (guard < 60) begin
      @(negedge clk);
      guard++;
      if (busy) cnt++;
      else break;
    end
    check("busyCycles", 32'(cnt), 32'd33);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2);
    issue(3'd7, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd7, 32'd0);
    issue(3'd6, 32'd7, 32'd0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start while busy is ignored, including in the done cycle
    issue(3'd4, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    aluIn1 = 32'd9;
    aluIn2 = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("doneSeen", {31'b0, done}, 32'd1);
    start  = 1'b1;
    funct3 = 3'd0;
    aluIn1 = 32'd5;
    aluIn2 = 32'd6;
    pushExp(3'd0, 32'd5, 32'd6, edgeCount + 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset mid-operation
    issue(3'd0, 32'h1234_5678, 32'h0000_0011);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abortBusy", {31'b0, busy}, 32'd0);
    check("abortDone", {31'b0, done}, 32'd0);
    check("abortResult", result, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4);

    // Random traffic with boundary patterns mixed in
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        4: a = 32'h8000_0000;
        default: ;
      endcase
      issue(op, a, b);
    end

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit for the execute stage.
- Sits directly downstream of the ALU operand selectors and consumes the selected aluIn1/aluIn2 in parallel with the ALU.
- Computes one M-extension operation per start pulse using a radix-2 shift-add multiplier and a restoring divider.
- The result goes to the writeback mux; busy is used by the control unit to stall the pipeline.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- aluIn1  input  WIDTH  operand rs1 (multiplicand/dividend)
- aluIn2  input  WIDTH  operand rs2 (multiplier/divisor)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; result valid in this cycle
- result  output  WIDTH  registered result; holds until the next done

Behaviour:
- Reset: rst high at a clock edge forces state=IDLE, busy=0, done=0, result=0 and clears all internal registers. Reset is honoured in every state, so an operation in flight is aborted with no done.
- States: IDLE, CALC, DONE.
- IDLE:
  - Acceptance: start=1 captures funct3, operands, the sign flags and the absolute values, and clears the iteration counter.
  - Sign flags: sa=aluIn1[31] for MULH/MULHSU/DIV/REM; sb=aluIn2[31] for MULH/DIV/REM. Both are 0 for all other ops.
  - Special cases:
    - Divide ops with aluIn2==0 go directly to DONE. DIV/DIVU give all ones; REM/REMU give aluIn1.
    - DIV/REM with aluIn1=0x80000000 and aluIn2=0xFFFFFFFF go directly to DONE. DIV gives 0x80000000; REM gives 0.
    - Otherwise the next state is CALC.
- CALC:
  - Runs exactly WIDTH cycles with counter 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on |a|,|b|.
  - Divide: restoring divide on |a|/|b| producing quotient and remainder.
  - After the counter reaches WIDTH-1, the next state is DONE.
- Sign fix-up, applied on the edge entering DONE:
  - Product negated if sa^sb. Quotient negated if sa^sb. Remainder negated if sa.
  - MUL takes product[31:0]. MULH/MULHSU/MULHU take product[63:32].
  - result register is loaded with the selected value.
- DONE: done=1 and busy=1 for one cycle, then unconditionally back to IDLE.
- Latency: counting from the edge that samples start, normal ops assert done in the cycle after edge WIDTH+1 (33 edges). Special cases assert done after 1 edge.
- Back-to-back: start is ignored while busy=1, including the DONE cycle. A new request is accepted at the earliest in the cycle after done.
- Operand stability: inputs may change freely after the accepting edge; only captured values are used.
- done is never high when busy=0. result never changes except on the edge entering DONE or on reset.

Test Plan:
- MUL: aluIn1=7, aluIn2=0xFFFFFFFD -> done exactly 33 edges after start; result 0xFFFFFFEB; busy high for 33 cycles.
- High products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed division: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Special cases, each with done 1 edge after start:
  - DIVU 7/0 -> 0xFFFFFFFF.
  - REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Start while busy: a second start with different operands at cycle 5 of CALC -> ignored; first result still correct; a new start the cycle after done is accepted.
- Reset mid-operation: rst at cycle 10 of CALC -> the next cycle busy=0, done=0, result=0; no done pulse follows; a subsequent MUL 3*4 -> 12.
